clk_div_multi: RTL
==================

// Module: clk_div_multi
// PURPOSE
//  Multi-channel, runtime-programmable clock divider / tick generator.
//  Each of NUM_CH channels divides clk_i by its own divisor.
//  Each channel drives a registered divided clock and a one-cycle tick (clock enable) per period.
//  Serves peripheral timing (UART baud, SPI SCLK, timers) off the core clock.
//  Divisors are glitch-free: changes apply only at period boundaries.
// PARAMETERS
//  NUM_CH   4    number of independent channels
//  DIV_W    16   divisor width in bits; max period 2**DIV_W-1 cycles
// PORTS
//  clk_i    in   1            system clock
//  rst_i    in   1            reset, asynchronous, active-high
//  en_i     in   NUM_CH       per-channel enable
//  sync_i   in   1            one-cycle pulse: restart all enabled channels in phase
//  div_i    in   NUM_CH*DIV_W per-channel divisor P; channel i = div_i[i*DIV_W +: DIV_W]
//  clk_o    out  NUM_CH       divided clocks, registered
//  tick_o   out  NUM_CH       one-cycle pulse per period, registered
// BEHAVIOUR
//  - Reset: rst_i, asynchronous, active-high; clock clk_i.
//    During reset: all counters, active divisors, clk_o and tick_o are 0.
//  - Per channel: cnt (DIV_W bits) and div_act (latched divisor P).
//    P = max(div_act, 2); values 0 and 1 are clamped to 2.
//    H = P>>1 high cycles (floor).
//  - Outputs are registered from next-state cnt:
//    clk_o = en & (cnt < H); tick_o = en & (cnt == P-1).
//    Result per period: clk_o high for H cycles, then low for P-H cycles; tick_o high in the last low cycle.
//  - Priority at each clk_i edge, per channel: en low > sync > wrap > count.
//  - en_i low: cnt <= 0; clk_o <= 0; tick_o <= 0; div_act is don't-care.
//  - Enable edge (en was 0, now 1): div_act <= div_i; cnt <= 0; clk_o <= 1 the same edge. No extra latency.
//  - sync_i high and en high: cnt <= 0; div_act <= div_i; clk_o <= 1; tick_o <= 0.
//    The period in progress is abandoned.
//  - Wrap (cnt == P-1): cnt <= 0; div_act <= div_i (shadow load); clk_o <= 1.
//  - Otherwise: cnt <= cnt + 1.
//  - div_i changes mid-period have no effect until the next wrap, enable edge or sync.
//    No runt or stretched pulses are produced.
//  - Counter never exceeds P-1. A divisor of all-ones gives P = 2**DIV_W-1.
//  - Channels are fully independent except for the shared sync_i.
//  - Reset asserted mid-period: outputs go 0 immediately (async).
//    After release: first edge with en high behaves as an enable edge.
// CONFIGURATION
//  CLKDIV_DUTY_EN defined:
//   - Adds input port high_i, NUM_CH*DIV_W bits, per-channel high time.
//   - H = clamp(high_i, 1, P-1), latched together with div_act at the same load events.
//  CLKDIV_DUTY_EN undefined:
//   - No high_i port. H = P>>1 as above.
// TESTING
//  1 ch0 div=4, en0 rises -> clk_o[0] = 1,1,0,0 repeating; tick_o[0] high on every 4th cycle (cnt=3).
//  2 ch0 div=5 -> clk_o 1,1,0,0,0; tick on 5th cycle. ch1 div=0 and div=1 -> period 2: clk 1,0; tick every 2nd cycle.
//  3 ch0 div=4, change div_i to 6 at cnt=1 -> current period finishes at 4 cycles; next period is 6 (1,1,1,0,0,0).
//  4 ch0 div=4 at cnt=2, ch1 div=6 at cnt=4, pulse sync_i -> next cycle both channels have cnt=0, clk_o=1; edges aligned after.
//  5 Assert rst_i mid-period -> clk_o=tick_o=0 without a clock edge. Release with en high -> restart from cnt=0, clk_o=1.
//  6 CLKDIV_DUTY_EN, div=8: high=3 -> clk 3 high / 5 low. high=0 -> 1 high. high=9 -> 7 high; tick unaffected.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider / tick generator.
//
// Each channel divides clk_i by its own divisor P (values 0 and 1 act as 2).
// clk_o is high for H cycles and then low for P-H cycles. tick_o pulses in the
// last low cycle of every period. A new divisor is picked up only at a period
// boundary: a wrap, an enable edge or a sync_i pulse. This keeps the outputs
// free of runt and stretched pulses.
//
// Optional feature: define CLKDIV_DUTY_EN to add the high_i port. It gives a
// per-channel high time H, clamped to 1..P-1, which is latched together with
// the divisor. Without the macro, H = P >> 1.

module clk_div_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic                    sync_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
`ifdef CLKDIV_DUTY_EN
    input  logic [NUM_CH*DIV_W-1:0] high_i,
`endif
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o
);

    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
    localparam logic [DIV_W-1:0] DivTwo = DIV_W'(2);

    // Effective period: divisors below 2 cannot form a high and a low phase.
    function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] d);
        return (d < DivTwo) ? DivTwo : d;
    endfunction

`ifdef CLKDIV_DUTY_EN
    // Effective high time: keep at least one high and one low cycle per period.
    function automatic logic [DIV_W-1:0] eff_high(input logic [DIV_W-1:0] hi,
                                                  input logic [DIV_W-1:0] p);
        if (hi == '0) begin
            return DivOne;
        end
        if (hi > p - DivOne) begin
            return p - DivOne;
        end
        return hi;
    endfunction
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] div_in;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_d;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_d;
        logic [DIV_W-1:0] p_q;
        logic [DIV_W-1:0] p_d;
        logic [DIV_W-1:0] h_d;
        logic             en_q;
        logic             load;
        logic             clk_q;
        logic             clk_d;
        logic             tick_q;
        logic             tick_d;

        assign div_in = div_i[g*DIV_W +: DIV_W];
        assign p_q    = eff_period(div_q);

        // Period boundary: enable edge, sync pulse or wrap of the running period.
        assign load = !en_q || sync_i || (cnt_q == p_q - DivOne);

`ifdef CLKDIV_DUTY_EN
        logic [DIV_W-1:0] high_in;
        logic [DIV_W-1:0] high_q;
        logic [DIV_W-1:0] high_d;

        assign high_in = high_i[g*DIV_W +: DIV_W];

        // The high time is shadow-loaded together with the divisor.
        always_comb begin
            high_d = high_q;
            if (en_i[g] && load) begin
                high_d = high_in;
            end
        end

        assign h_d = eff_high(high_d, p_d);
`else
        assign h_d = p_d >> 1;
`endif

        // Next counter and divisor. Priority: disable > restart/wrap > count.
        always_comb begin
            cnt_d = cnt_q;
            div_d = div_q;
            if (!en_i[g]) begin
                cnt_d = '0;
            end else if (load) begin
                cnt_d = '0;
                div_d = div_in;
            end else begin
                cnt_d = cnt_q + DivOne;
            end
        end

        assign p_d    = eff_period(div_d);
        // Outputs are decoded from the next state, so they carry no extra latency.
        assign clk_d  = en_i[g] && (cnt_d < h_d);
        assign tick_d = en_i[g] && (cnt_d == p_d - DivOne);

        // Channel state and registered outputs; reset clears everything at once.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                en_q   <= 1'b0;
                cnt_q  <= '0;
                div_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
`ifdef CLKDIV_DUTY_EN
                high_q <= '0;
`endif
            end else begin
                en_q   <= en_i[g];
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
`ifdef CLKDIV_DUTY_EN
                high_q <= high_d;
`endif
            end
        end

        assign clk_o[g]  = clk_q;
        assign tick_o[g] = tick_q;
    end

endmodule
